// File: rtl/audio_pkg.sv
// audio_pkg: note codes, half-period table, ROM entry layout and tune tables.
package audio_pkg;
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_D5 = 4'd1;
  localparam logic [3:0] NOTE_D6 = 4'd2;
  localparam logic [3:0] NOTE_D7 = 4'd3;
  localparam logic [3:0] NOTE_C1 = 4'd4;
  localparam logic [3:0] NOTE_C2 = 4'd5;
  localparam logic [3:0] NOTE_C3 = 4'd6;
  localparam int ENTRY_W = 7;
  localparam int CODE_LSB = 3;
  localparam int BEATS_LSB = 1;
  localparam int LAST_BIT = 0;
  typedef struct packed {
    logic [3:0] code;
    logic [1:0] beats;
    logic last;
  } entry_t;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  // half-periods in 100 MHz clock cycles, indexed by note code
  localparam logic [17:0] pkg_half [16] = '{
    18'd0, 18'd255102, 18'd227273, 18'd202429, 18'd191204, 18'd170358, 18'd151745, 18'd0,
    18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0
  };
  localparam logic [3:0] theme_code [32] = '{
    NOTE_C1, NOTE_C2, NOTE_C3, NOTE_C2, NOTE_C1, NOTE_D5, NOTE_D6, NOTE_D7,
    NOTE_REST, NOTE_C1, NOTE_C1, NOTE_C2, NOTE_C3, NOTE_D7, NOTE_D6, NOTE_D5,
    NOTE_REST, NOTE_C3, NOTE_C2, NOTE_C1, NOTE_D7, NOTE_D6, NOTE_D5, NOTE_C1,
    NOTE_REST, NOTE_C1, NOTE_C2, NOTE_C3, NOTE_C3, NOTE_C1, NOTE_REST, NOTE_REST
  };
  localparam logic [1:0] theme_beats [32] = '{
    2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0,
    2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0
  };
  // tune 0 is the short test jingle, tune 1 the 30-note game theme
  function automatic entry_t tune_entry(input int tune, input logic [4:0] idx);
    entry_t rest_end;
    rest_end = entry_t'{NOTE_REST, 2'd0, 1'b1};
    return tune == 0 ? (idx == 5'd0 ? entry_t'{NOTE_C1, 2'd0, 1'b0} :
                        idx == 5'd1 ? entry_t'{NOTE_REST, 2'd1, 1'b0} :
                        idx == 5'd2 ? entry_t'{NOTE_D5, 2'd0, 1'b1} : rest_end) :
           tune == 1 && idx < 5'd30 ? entry_t'{theme_code[idx], theme_beats[idx], idx == 5'd29} :
           rest_end;
  endfunction
endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational {tune, index} -> note entry lookup.
module melody_rom import audio_pkg::*; #(
  parameter int TS_W = 1,
  parameter int IDX_W = 5
) (
  input  logic [TS_W-1:0]  tune,
  input  logic [IDX_W-1:0] idx,
  output entry_t           entry
);
  assign entry = 32'(idx) >= 32 ? entry_t'{NOTE_REST, 2'd0, 1'b1} : tune_entry(int'(tune), 5'(idx));
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays stored tunes as a square wave with rests, note gaps,
// looping and octave transposition.
module melody_sequencer import audio_pkg::*; #(
  parameter int NUM_TUNES = 2,
  parameter int TUNE_LEN = 32,
  parameter int HALF_W = 18,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int TONE_SHIFT = 0,
  localparam int TS_W = NUM_TUNES > 1 ? $clog2(NUM_TUNES) : 1,
  localparam int IDX_W = $clog2(TUNE_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [TS_W-1:0]  tune_sel,
  output logic             pwm,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx
);
  localparam int DUR_W = $clog2(4 * BEAT_CYCLES);
  localparam logic [DUR_W-1:0] GAP_END = DUR_W'(GAP_CYCLES - 1);
  state_t state;
  entry_t entry;
  logic [TS_W-1:0] tune;
  logic [HALF_W-1:0] half, half_n, tone_cnt;
  logic [DUR_W-1:0] dur_cnt, play_end;
  logic [1:0] beats;
  logic rest, last;
  melody_rom #(.TS_W(TS_W), .IDX_W(IDX_W)) u_rom (.tune(tune), .idx(note_idx), .entry(entry));
  assign half_n = HALF_W'(pkg_half[entry.code] >> TONE_SHIFT);
  // PLAY covers the note's beats minus the trailing silent gap
  assign play_end = DUR_W'((32'(beats) + 32'd1) * 32'(BEAT_CYCLES) - 32'(GAP_CYCLES) - 32'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pwm <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      note_idx <= '0;
      tune <= '0;
      half <= '0;
      tone_cnt <= '0;
      dur_cnt <= '0;
      beats <= '0;
      rest <= 1'b1;
      last <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        pwm <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            tune <= tune_sel;
            note_idx <= '0;
            busy <= 1'b1;
            state <= LOAD;
          end
          LOAD: begin
            half <= half_n;
            rest <= entry.code == NOTE_REST || half_n == '0;
            beats <= entry.beats;
            last <= entry.last;
            tone_cnt <= '0;
            dur_cnt <= '0;
            pwm <= 1'b0;
            state <= PLAY;
          end
          PLAY: begin
            tone_cnt <= tone_cnt == half - 1'b1 ? '0 : tone_cnt + 1'b1;
            pwm <= dur_cnt == play_end ? 1'b0 : !rest && tone_cnt == half - 1'b1 ? !pwm : pwm;
            dur_cnt <= dur_cnt == play_end ? '0 : dur_cnt + 1'b1;
            state <= dur_cnt == play_end ? GAP : PLAY;
          end
          default: begin
            dur_cnt <= dur_cnt + 1'b1;
            if (dur_cnt == GAP_END) begin
              dur_cnt <= '0;
              if (!last && note_idx != IDX_W'(TUNE_LEN - 1)) begin
                note_idx <= note_idx + 1'b1;
                state <= LOAD;
              end else if (loop_en) begin
                note_idx <= '0;
                state <= LOAD;
              end else begin
                done <= 1'b1;
                busy <= 1'b0;
                state <= IDLE;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed table-driven checks of tune timing, looping,
// stop, async reset and start-while-busy.
module tb_melody_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic tune_sel = 1'b0;
  logic pwm, busy, done;
  logic [4:0] note_idx;
  int total = 0, passed = 0, rises = 0, dones = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .NUM_TUNES(2), .TUNE_LEN(32), .HALF_W(18),
    .BEAT_CYCLES(100), .GAP_CYCLES(10), .TONE_SHIFT(14)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .tune_sel(tune_sel), .pwm(pwm), .busy(busy), .done(done), .note_idx(note_idx)
  );

  typedef struct {
    int cyc;
    logic pwm, busy, done;
    logic [4:0] idx;
  } vec_t;
  vec_t tab[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int obs();
    return int'({pwm, busy, done, note_idx});
  endfunction

  task automatic begin_tune(input logic ts);
    start = 1'b1;
    tune_sel = ts;
    tick();
    start = 1'b0;
  endtask

  // n counts clock edges since the start edge of the current pass
  task automatic run(input string tag, input int from, input int to, input int poke);
    logic prev;
    prev = pwm;
    for (int n = from; n <= to; n++) begin
      if (n > from) tick();
      if (n == poke) begin start = 1'b1; tune_sel = 1'b1; end
      else if (n == poke + 1) begin start = 1'b0; tune_sel = 1'b0; end
      if (pwm && !prev) rises++;
      prev = pwm;
      if (done) dones++;
      foreach (tab[i])
        if (tab[i].cyc == n)
          chk($sformatf("%s n=%0d", tag, n), obs(),
              int'({tab[i].pwm, tab[i].busy, tab[i].done, tab[i].idx}));
    end
  endtask

  initial begin
    tab.push_back('{0, 0, 1, 0, 5'd0});
    tab.push_back('{1, 0, 1, 0, 5'd0});
    tab.push_back('{11, 0, 1, 0, 5'd0});
    tab.push_back('{12, 1, 1, 0, 5'd0});
    tab.push_back('{22, 1, 1, 0, 5'd0});
    tab.push_back('{23, 0, 1, 0, 5'd0});
    tab.push_back('{34, 1, 1, 0, 5'd0});
    tab.push_back('{78, 1, 1, 0, 5'd0});
    tab.push_back('{89, 0, 1, 0, 5'd0});
    tab.push_back('{91, 0, 1, 0, 5'd0});
    tab.push_back('{100, 0, 1, 0, 5'd0});
    tab.push_back('{101, 0, 1, 0, 5'd1});
    tab.push_back('{200, 0, 1, 0, 5'd1});
    tab.push_back('{302, 0, 1, 0, 5'd2});
    tab.push_back('{303, 0, 1, 0, 5'd2});
    tab.push_back('{317, 0, 1, 0, 5'd2});
    tab.push_back('{318, 1, 1, 0, 5'd2});
    tab.push_back('{333, 0, 1, 0, 5'd2});
    tab.push_back('{348, 1, 1, 0, 5'd2});
    tab.push_back('{392, 1, 1, 0, 5'd2});
    tab.push_back('{393, 0, 1, 0, 5'd2});
    tab.push_back('{402, 0, 1, 0, 5'd2});
    tab.push_back('{403, 0, 0, 1, 5'd2});
    tab.push_back('{404, 0, 0, 0, 5'd2});

    repeat (3) tick();
    chk("reset state", obs(), 0);
    rst = 1'b0;
    tick();
    chk("idle after reset", obs(), 0);

    begin_tune(1'b0);
    rises = 0; dones = 0;
    run("tune0", 0, 404, -10);
    chk("tune0 rises", rises, 7);
    chk("tune0 done pulses", dones, 1);

    loop_en = 1'b1;
    begin_tune(1'b0);
    rises = 0; dones = 0;
    run("loop1", 0, 402, -10);
    tick();
    chk("loop wrap state", obs(), int'({1'b0, 1'b1, 1'b0, 5'd0}));
    chk("loop no done", dones, 0);
    loop_en = 1'b0;
    run("loop2", 0, 404, -10);
    chk("loop rises", rises, 14);
    chk("loop done pulses", dones, 1);

    begin_tune(1'b0);
    dones = 0;
    run("prestop", 0, 40, -10);
    chk("pwm before stop", int'(pwm), 1);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("stop state", obs(), 0);
    for (int k = 0; k < 20; k++) begin tick(); if (done || busy || pwm) dones++; end
    chk("quiet after stop", dones, 0);

    begin_tune(1'b0);
    run("prereset", 0, 350, -10);
    chk("pre-reset state", obs(), int'({1'b1, 1'b1, 1'b0, 5'd2}));
    #2 rst = 1'b1;
    #1 chk("async reset", obs(), 0);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (done || busy || pwm) dones++; end
    chk("quiet after reset", dones, 0);

    begin_tune(1'b0);
    dones = 0;
    run("busystart", 0, 404, 50);
    chk("busystart done pulses", dones, 1);

    begin_tune(1'b1);
    chk("tune1 start", obs(), int'({1'b0, 1'b1, 1'b0, 5'd0}));
    repeat (11) tick();
    chk("tune1 C1 low", int'(pwm), 0);
    tick();
    chk("tune1 C1 high", int'(pwm), 1);
    for (int k = 0; k < 20000 && !done; k++) tick();
    chk("tune1 done", int'(done), 1);
    chk("tune1 last idx", int'(note_idx), 29);
    tick();
    chk("tune1 idle", int'({busy, done}), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Parametrised successor to the fixed-tune square-wave player. It plays one of NUM_TUNES stored melodies from a note ROM. Each entry carries a pitch code, a duration in beats and an end-of-tune flag. The block adds start/stop/loop control, silent rests, a configurable articulation gap between notes, and octave transposition. It sits between the game controller (start/stop/tune select) and the buzzer pin (pwm).

Parameters:
NUM_TUNES, 2, number of stored tunes; tune_sel width TS_W = max(1, clog2(NUM_TUNES)).
TUNE_LEN, 32, maximum entries per tune; note_idx width IDX_W = clog2(TUNE_LEN).
HALF_W, 18, width of the tone half-period counter.
BEAT_CYCLES, 25_000_000, clk cycles per beat (0.25 s at 100 MHz); must be >= 2.
GAP_CYCLES, 1_000_000, silent cycles at the end of every note; 1 <= GAP_CYCLES < BEAT_CYCLES.
TONE_SHIFT, 0, right-shift applied to every ROM half-period; each step raises pitch one octave.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle start request
stop  in  1  single-cycle abort request
loop_en  in  1  level; sampled at end of last note
tune_sel  in  TS_W  tune index, latched on accepted start
pwm  out  1  square-wave audio output
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on natural completion
note_idx  out  IDX_W  index of the entry currently loaded

Behaviour:
- Reset (async): state=IDLE; pwm=0, busy=0, done=0, note_idx=0; all counters 0.
- ROM entry fields: note code 4 bits, beats 2 bits (encoding 0..3 = 1..4 beats), last 1 bit.
- Half-period = pkg_half[code] >> TONE_SHIFT, truncated to HALF_W bits.
- Code NOTE_REST, or a shifted half-period of 0, is treated as a rest: pwm held 0.
- IDLE: start=1 and stop=0 -> latch tune_sel, note_idx=0, go to LOAD. The start is accepted on the cycle it is sampled.
- LOAD (exactly 1 cycle): register half-period, beats, last; clear tone and beat counters; pwm=0 -> PLAY.
- PLAY: lasts exactly beats*BEAT_CYCLES - GAP_CYCLES cycles.
  - The tone counter counts 0..half-1. At half-1 it wraps and toggles pwm, giving an output period of 2*half cycles.
  - The first rising edge of pwm occurs half cycles after PLAY entry.
  - At the end of PLAY -> GAP.
- GAP (exactly GAP_CYCLES cycles): pwm=0. At the end of GAP:
  - last=0 and note_idx != TUNE_LEN-1: note_idx+1, go to LOAD.
  - Otherwise (last entry, or index TUNE_LEN-1 reached): if loop_en=1, note_idx=0 and go to LOAD. Else done=1 for one cycle, go to IDLE.
- Note-to-note spacing is therefore beats*BEAT_CYCLES + 1 cycles.
- stop=1 in any state: next cycle state=IDLE, pwm=0, busy=0, done stays 0. stop has priority over start in the same cycle.
- start while busy is ignored; there is no restart and tune_sel is not re-latched.
- Changing tune_sel mid-tune has no effect.
- loop_en is only sampled at the end of the last note's GAP.
- pwm, busy and done are registered outputs, with no combinational path from any input.

Decomposition:
- Package audio_pkg holds:
  - Note code constants NOTE_REST, NOTE_D5, NOTE_D6, NOTE_D7, NOTE_C1, NOTE_C2, NOTE_C3 with half-periods 255102, 227273, 202429, 191204, 170358, 151745 at 100 MHz.
  - The entry packing (code/beats/last) with field offsets.
  - The tune tables.
  - Tune 0 (test jingle): {C1, 1 beat}, {REST, 2 beats}, {D5, 1 beat, last}.
  - Tune 1: the 30-note game theme.
- Sub-module melody_rom: combinational lookup {tune, idx} -> entry. It is kept separate so tune content changes do not touch the controller.
- The FSM, tone divider and beat timer stay in melody_sequencer.

Test Plan:
Overrides for all tests: BEAT_CYCLES=100, GAP_CYCLES=10, TONE_SHIFT=14, giving C1 half=11 and D5 half=15.
1. Reset mid-PLAY of tune 0 -> pwm, busy, done and note_idx all 0 immediately. No activity until the next start.
2. start with tune_sel=0 -> busy=1 next cycle; LOAD 1 cycle; pwm toggles every 11 cycles for 90 cycles; then 0 for 10 cycles; note_idx=1.
3. Continue tune 0 -> note_idx=1 gives pwm=0 for 201 cycles (1+190+10). note_idx=2 gives a 30-cycle pwm period for 90 cycles. Then done pulses exactly once, busy=0, total 403 cycles from start.
4. Tune 0 with loop_en=1 -> after the last GAP, note_idx returns to 0 with no done pulse; the sequence repeats identically.
5. stop asserted at PLAY cycle 40 while pwm=1, with start also asserted -> IDLE, pwm=0, busy=0, done=0 one cycle later.
6. start while busy with tune_sel=1 -> ignored; tune 0 timing is unchanged. A later start with tune_sel=1 plays tune 1 entry 0 (C1) and runs to index 31 or the last flag.
